// File: rtl/cpu_pkg.sv
// Shared CPU types: hazard FSM state encoding and register-address width default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Default register-address width (8 architectural registers, r0 reads as zero)
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

endpackage : cpu_pkg

// File: rtl/hazard_detect.sv
// Compares ID-stage sources and stack use against the instruction in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results feed the stall decision in hazard_ctrl.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_uses_rs1,
  input  logic          id_uses_rs2,
  input  logic          id_stack_op,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_stack_op,
  output logic          load_use,
  output logic          stack_conflict
);

  logic ex_load_live;
  logic rs1_match;
  logic rs2_match;

  // A load only hurts when it really writes a non-zero register that ID is about to read;
  // back-to-back stack ops conflict because SP is only updated in MEM.
  always_comb begin
    ex_load_live   = ex_mem_read && ex_reg_write && (ex_rd != '0);
    rs1_match      = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_match      = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use       = ex_load_live && (rs1_match || rs2_match);
    stack_conflict = id_stack_op && ex_stack_op;
  end

endmodule : hazard_detect

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing: stall, flush and bubble control plus halt-drain FSM and perf counters.
// Latency: control outputs are combinational (same cycle); state and counters update on the next edge.
// Backpressure: it is the backpressure source; pc_write/ifid_write low freezes the front end.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW       = cpu_pkg::REG_AW,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_stack_op,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_stack_op,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // Drain counter only has to hold DRAIN_CYCLES-1
  localparam int             DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  hazard_state_t  state, state_nxt;
  logic [DCW-1:0] drain_cnt, drain_cnt_nxt;
  logic           load_use;
  logic           stack_conflict;
  logic           stall;
  logic           stall_inc;
  logic           flush_inc;

  hazard_detect #(
    .AW (REG_AW)
  ) u_detect (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_stack_op    (id_stack_op),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_stack_op    (ex_stack_op),
    .load_use       (load_use),
    .stack_conflict (stack_conflict)
  );

  assign stall = load_use || stack_conflict;

  // Priority resolution and next state: taken branch beats stall, stall beats halt; drain ignores hazards
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          // Wrong-path instructions in IF and ID are squashed; a halt in ID dies here too
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
        end else if (stall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (id_halt) begin
          // Halt moves on to EX; nothing younger is fetched behind it
          pc_write      = 1'b0;
          ifid_flush    = 1'b1;
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (drain_cnt == '0) begin
          state_nxt = HALTED;
        end else begin
          drain_cnt_nxt = drain_cnt - DCW'(1);
        end
      end
      HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    // While reset is held the pipeline sees plain RUN behaviour and nothing is counted
    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      halted      = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Saturating performance counters: stick at all-ones rather than wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush_inc && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs a cycle-indexed model.
// Latency: checks combinational outputs mid-cycle, registered counters after each edge.
// Backpressure: n/a.
module tb_hazard_ctrl;

  localparam int AW    = 3;
  localparam int D     = 3;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, id_stack_op, id_halt;
  logic          ex_reg_write, ex_mem_read, ex_stack_op, ex_branch_taken;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, halted;
  logic [CW-1:0] stall_count, flush_count;
  logic [4:0]    outs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: halt is remembered as the cycle it left ID; counts kept as plain integers
  int m_halt_at  = -1;
  int m_stalls   = 0;
  int m_flushes  = 0;

  hazard_ctrl #(
    .REG_AW       (AW),
    .DRAIN_CYCLES (D),
    .CNT_W        (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_stack_op     (id_stack_op),
    .id_halt         (id_halt),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_stack_op     (ex_stack_op),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .halted          (halted),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, halted}
  assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, halted};

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic model_stall();
    logic lu;
    lu = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    return lu || (id_stack_op && ex_stack_op);
  endfunction

  function automatic logic [4:0] model_out();
    if (rst)                                   return 5'b11000;
    if (m_halt_at >= 0 && cyc > m_halt_at + D) return 5'b00111;
    if (m_halt_at >= 0)                        return 5'b00110;
    if (ex_branch_taken)                       return 5'b11110;
    if (model_stall())                         return 5'b00010;
    if (id_halt)                               return 5'b01100;
    return 5'b11000;
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge
  task automatic tick();
    int h, s, f;
    h = m_halt_at; s = m_stalls; f = m_flushes;
    if (rst) begin
      h = -1; s = 0; f = 0;
    end else if (m_halt_at < 0) begin
      if (ex_branch_taken)    f = sat(f);
      else if (model_stall()) s = sat(s);
      else if (id_halt)       h = cyc;
    end
    @(posedge clk);
    m_halt_at = h; m_stalls = s; m_flushes = f;
    cyc++;
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_stack_op = 0; id_halt = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_stack_op = 0; ex_branch_taken = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); rst = 0;
  endtask

  task automatic set_load_use(input logic [AW-1:0] rd);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd;
    id_uses_rs1 = 1; id_rs1 = rd;
  endtask

  task automatic test_reset();
    rst = 1; idle(); #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL reset_cycle_outs got=%b want=%b", outs, 5'b11000); end
    tick(); rst = 0; #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL post_reset_outs got=%b want=%b", outs, 5'b11000); end
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL post_reset_counts got=%0d/%0d want=0/0", stall_count, flush_count);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle(); set_load_use(3'd3); #3;
    checks++;
    if (outs !== 5'b00010) begin errors++; $display("FAIL load_use_stall got=%b want=%b", outs, 5'b00010); end
    tick();
    idle(); #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL load_use_released got=%b want=%b", outs, 5'b11000); end
    checks++;
    if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count got=%0d want=1", stall_count); end
    set_load_use(3'd0); id_uses_rs2 = 1; #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL load_r0_no_stall got=%b want=%b", outs, 5'b11000); end
    tick();
    idle(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3'd5;
    id_uses_rs1 = 0; id_rs1 = 3'd5; id_uses_rs2 = 1; id_rs2 = 3'd5; #3;
    checks++;
    if (outs !== 5'b00010) begin errors++; $display("FAIL load_use_rs2 got=%b want=%b", outs, 5'b00010); end
    tick();
    idle(); #3;
    checks++;
    if (stall_count !== 16'd2) begin errors++; $display("FAIL load_use_count2 got=%0d want=2", stall_count); end
  endtask

  task automatic test_branch_priority();
    idle(); set_load_use(3'd4); ex_branch_taken = 1; #3;
    checks++;
    if (outs !== 5'b11110) begin errors++; $display("FAIL branch_over_stall got=%b want=%b", outs, 5'b11110); end
    tick();
    idle(); #3;
    checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd2) begin
      errors++; $display("FAIL branch_counts got=%0d/%0d want=1/2", flush_count, stall_count);
    end
  endtask

  task automatic test_stack();
    idle(); ex_stack_op = 1; id_stack_op = 1; #3;
    checks++;
    if (outs !== 5'b00010) begin errors++; $display("FAIL stack_stall got=%b want=%b", outs, 5'b00010); end
    tick();
    ex_stack_op = 0; #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL stack_in_mem got=%b want=%b", outs, 5'b11000); end
    tick();
  endtask

  task automatic test_halt_timing();
    do_reset();
    idle(); id_halt = 1; #3;
    checks++;
    if (outs !== 5'b01100) begin errors++; $display("FAIL halt_issue got=%b want=%b", outs, 5'b01100); end
    tick();
    // Hazard and branch inputs are present during drain and must be ignored
    idle(); set_load_use(3'd2); ex_branch_taken = 1;
    for (int k = 1; k <= D + 5; k++) begin
      #3;
      checks++;
      if (k <= D && outs !== 5'b00110) begin
        errors++; $display("FAIL drain_k%0d got=%b want=%b", k, outs, 5'b00110);
      end else if (k > D && outs !== 5'b00111) begin
        errors++; $display("FAIL halted_k%0d got=%b want=%b", k, outs, 5'b00111);
      end
      tick();
    end
    checks++;
    if (flush_count !== 16'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL drain_no_count got=%0d/%0d want=0/0", flush_count, stall_count);
    end
    idle(); rst = 1; #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL rst_in_halted got=%b want=%b", outs, 5'b11000); end
    tick(); rst = 0; #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL after_rst_halted got=%b want=%b", outs, 5'b11000); end
    tick();
  endtask

  task automatic test_halt_branch();
    idle(); id_halt = 1; ex_branch_taken = 1; #3;
    checks++;
    if (outs !== 5'b11110) begin errors++; $display("FAIL halt_with_branch got=%b want=%b", outs, 5'b11110); end
    tick();
    idle();
    for (int k = 0; k < D + 3; k++) begin
      #3;
      checks++;
      if (outs !== 5'b11000) begin errors++; $display("FAIL halt_discarded_k%0d got=%b want=%b", k, outs, 5'b11000); end
      tick();
    end
  endtask

  task automatic test_halt_stall();
    idle(); id_halt = 1; set_load_use(3'd6); #3;
    checks++;
    if (outs !== 5'b00010) begin errors++; $display("FAIL halt_with_stall got=%b want=%b", outs, 5'b00010); end
    tick();
    idle(); id_halt = 1; #3;
    checks++;
    if (outs !== 5'b01100) begin errors++; $display("FAIL halt_retry got=%b want=%b", outs, 5'b01100); end
    tick();
    idle(); #3;
    checks++;
    if (outs !== 5'b00110) begin errors++; $display("FAIL halt_retry_drain got=%b want=%b", outs, 5'b00110); end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst             = ($urandom_range(0, 49) == 0);
      id_rs1          = AW'($urandom_range(0, 7));
      id_rs2          = AW'($urandom_range(0, 7));
      ex_rd           = AW'($urandom_range(0, 7));
      id_uses_rs1     = ($urandom_range(0, 1) == 1);
      id_uses_rs2     = ($urandom_range(0, 1) == 1);
      id_stack_op     = ($urandom_range(0, 3) == 0);
      ex_stack_op     = ($urandom_range(0, 3) == 0);
      ex_reg_write    = ($urandom_range(0, 3) != 0);
      ex_mem_read     = ($urandom_range(0, 1) == 1);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      id_halt         = ($urandom_range(0, 19) == 0);
      #3;
      exp = model_out();
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL random_outs n=%0d got=%b want=%b", n, outs, exp); end
      checks++;
      if (stall_count !== CW'(m_stalls) || flush_count !== CW'(m_flushes)) begin
        errors++; $display("FAIL random_counts n=%0d got=%0d/%0d want=%0d/%0d", n, stall_count, flush_count, m_stalls, m_flushes);
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    idle(); set_load_use(3'd1);
    repeat (CMAX) tick();
    #3;
    checks++;
    if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h want=ffff", stall_count); end
    tick();
    #3;
    checks++;
    if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h want=ffff", stall_count); end
    idle(); id_halt = 1; tick();
    idle(); tick();
    #3;
    checks++;
    if (outs !== 5'b00110) begin errors++; $display("FAIL sat_in_drain got=%b want=%b", outs, 5'b00110); end
    rst = 1; #1;
    checks++;
    if (outs !== 5'b11000 || stall_count !== 16'hFFFF) begin
      errors++; $display("FAIL rst_in_drain_cycle got=%b/%h want=%b/ffff", outs, stall_count, 5'b11000);
    end
    tick(); rst = 0; #3;
    checks++;
    if (outs !== 5'b11000) begin errors++; $display("FAIL after_rst_drain got=%b want=%b", outs, 5'b11000); end
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL after_rst_counts got=%0d/%0d want=0/0", stall_count, flush_count);
    end
    tick();
  endtask

  initial begin
    rst = 1;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_stack();
    test_halt_timing();
    test_halt_branch();
    test_halt_stall();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hazard_ctrl
